// File: rtl/data_mem_responder.sv
// data_mem_responder: the responder side of the core's data-memory port.
// It serves a word-addressed RAM and a 4 KiB MMIO page. The page holds a
// console TX FIFO, which a consumer drains over valid/ready, and a
// free-running cycle counter. Reads return combinationally in the same cycle
// because the core is single-cycle.
module data_mem_responder #(
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned ADDR_W     = 10,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_F000,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FIFO_AW    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we,
    input  logic [31:0] address_to_mem,
    input  logic [31:0] data_to_mem,
    output logic [31:0] data_from_mem,
    output logic        cons_valid,
    output logic [7:0]  cons_data,
    input  logic        cons_ready
);

    // Word offsets inside the MMIO page (byte offset >> 2).
    localparam logic [9:0] OFF_CONS_TX   = 10'h000;
    localparam logic [9:0] OFF_CONS_STAT = 10'h001;
    localparam logic [9:0] OFF_CYCLE     = 10'h002;
    localparam logic [9:0] OFF_CONS_CNT  = 10'h003;

    localparam logic [FIFO_AW:0] PTR_ONE = 1;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic              is_mmio;
    logic [9:0]        mmio_word;
    logic [ADDR_W-1:0] ram_idx;
    logic              unused_addr_bits;

    assign is_mmio   = (address_to_mem[31:12] == MMIO_BASE[31:12]);
    assign mmio_word = address_to_mem[11:2];
    assign ram_idx   = address_to_mem[ADDR_W+1:2];

    // Byte-lane bits carry no meaning for word-only accesses.
    assign unused_addr_bits = ^address_to_mem[1:0];

    logic ram_we;
    logic tx_hit;
    logic stat_wr;
    logic cycle_wr;

    assign ram_we   = we & ~is_mmio;
    assign tx_hit   = we & is_mmio & (mmio_word == OFF_CONS_TX);
    assign stat_wr  = we & is_mmio & (mmio_word == OFF_CONS_STAT);
    assign cycle_wr = we & is_mmio & (mmio_word == OFF_CYCLE);

    // ------------------------------------------------------------------
    // Word RAM
    // ------------------------------------------------------------------
    logic [31:0] ram [DEPTH];

    // RAM write port. A read of the same word in the same cycle still sees
    // the old contents.
    // NOTE: storage arrays carry no reset; clearing them would need a
    // per-word reset network, and software never relies on initial contents.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= data_to_mem;
        end
    end

    // ------------------------------------------------------------------
    // Console TX FIFO
    // ------------------------------------------------------------------
    // The pointers carry one extra wrap bit, so full and empty can be told
    // apart without a separate flag.
    logic [FIFO_AW:0] rd_ptr;
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] count;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic             empty;
    logic             full;
    logic             pop;
    logic             push_accept;
    logic             ovf_set;
    logic             overflow;

    assign empty = (rd_ptr == wr_ptr);
    assign full  = (rd_ptr[FIFO_AW-1:0] == wr_ptr[FIFO_AW-1:0]) &&
                   (rd_ptr[FIFO_AW] != wr_ptr[FIFO_AW]);
    assign count = wr_ptr - rd_ptr;

    // The head signals come only from registered state. When the FIFO is
    // empty, cons_data is forced to 0, so the data output holds no stale
    // byte after a reset.
    assign cons_valid = ~empty;
    assign cons_data  = empty ? 8'h00 : fifo_mem[rd_ptr[FIFO_AW-1:0]];

    // A pop on a full FIFO frees a slot at the same edge. A push in that
    // cycle is accepted and does not count as an overflow.
    assign pop         = cons_valid & cons_ready;
    assign push_accept = tx_hit & (~full | pop);
    assign ovf_set     = tx_hit & full & ~pop;

    // Store each accepted console byte at the write pointer.
    always_ff @(posedge clk) begin
        if (push_accept) begin
            fifo_mem[wr_ptr[FIFO_AW-1:0]] <= data_to_mem[7:0];
        end
    end

    // Advance the FIFO pointers. An asynchronous reset discards every queued
    // byte.
    // NOTE: registered state is assigned with <= so every flop samples its
    // inputs from before the edge, whatever order the blocks run in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
        end
    end

    // Sticky overflow flag. If a drop and a clear happen together, the set
    // takes priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (stat_wr) begin
            overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Free-running cycle counter
    // ------------------------------------------------------------------
    logic [31:0] cycle;

    // Count every edge, and wrap naturally at 2^32. A software write loads
    // the counter in place of the increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle <= '0;
        end else if (cycle_wr) begin
            cycle <= data_to_mem;
        end else begin
            cycle <= cycle + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    // Return read data in the same cycle. MMIO registers and unmapped MMIO
    // offsets never alias RAM.
    // NOTE: the default at the top assigns every path, so no latch is
    // inferred.
    always_comb begin
        data_from_mem = '0;
        if (is_mmio) begin
            case (mmio_word)
                OFF_CONS_TX:   data_from_mem = '0;
                OFF_CONS_STAT: data_from_mem = {29'b0, overflow, full, empty};
                OFF_CYCLE:     data_from_mem = cycle;
                OFF_CONS_CNT:  data_from_mem = {{(32-FIFO_AW-1){1'b0}}, count};
                default:       data_from_mem = '0;
            endcase
        end else begin
            data_from_mem = ram[ram_idx];
        end
    end

endmodule
